// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Bundles every signal between the command sequencer and the rest of the
//   accumulator ALU system except the clock and reset.
//   master : command source / ALU side (drives powerOn, cmdValid, cmdOp,
//            cmdOperand, aluResult, aluOverflow, errClr)
//   slave  : the sequencer (drives cmdReady, accSel, aluOperand, outSel,
//            resValid, resData, resError, errFlag, state, opsCount)
//   Signals:
//     powerOn      block enable, looked at in OFF and READY only
//     cmdValid/cmdReady/cmdOp/cmdOperand   command handshake
//     accSel       one-hot accumulator mux: [2] persist, [1] load, [0] clear
//     aluOperand   registered second operand for the ALU input mux
//     outSel       one-hot ALU output mux: AND OR XOR NOT ADD SUB MULT
//     aluResult/aluOverflow                ALU output back to the sequencer
//     resValid/resData/resError            one-cycle result strobe
//     errFlag/errClr                       sticky overflow flag and its clear
//     state        OFF=00 READY=01 RUN=10 RUN_ERROR=11
//     opsCount     completed commands, saturating
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();

  logic             powerOn;
  logic             cmdValid;
  logic             cmdReady;
  logic [2:0]       cmdOp;
  logic [WIDTH-1:0] cmdOperand;
  logic [2:0]       accSel;
  logic [WIDTH-1:0] aluOperand;
  logic [6:0]       outSel;
  logic [WIDTH-1:0] aluResult;
  logic             aluOverflow;
  logic             resValid;
  logic [WIDTH-1:0] resData;
  logic             resError;
  logic             errFlag;
  logic             errClr;
  logic [1:0]       state;
  logic [CNT_W-1:0] opsCount;

  modport master (
    output powerOn, cmdValid, cmdOp, cmdOperand, aluResult, aluOverflow, errClr,
    input  cmdReady, accSel, aluOperand, outSel, resValid, resData, resError,
           errFlag, state, opsCount
  );

  modport slave (
    input  powerOn, cmdValid, cmdOp, cmdOperand, aluResult, aluOverflow, errClr,
    output cmdReady, accSel, aluOperand, outSel, resValid, resData, resError,
           errFlag, state, opsCount
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command sequencer for the 8-bit accumulator ALU. Accepts one opcode plus
//   operand over a valid/ready handshake, steers the accumulator and output
//   muxes for ALU_LAT cycles, then returns the ALU result with an overflow
//   qualifier. Owns the OFF/READY/RUN/RUN_ERROR power state machine.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  alu_cmd_sequencer_if.slave (command, mux selects, result, status)
//   Parameters:
//     WIDTH    datapath width
//     ALU_LAT  cycles from command accept to result sample, 1..15
//     CNT_W    width of the saturating completed-operation counter
module alu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    READY     = 2'b01,
    RUN       = 2'b10,
    RUN_ERROR = 2'b11
  } seqState_t;

  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MULT = 3'd6;
  localparam logic [2:0] OP_LOAD = 3'd7;

  localparam logic [2:0] SEL_HOLD    = 3'b000;
  localparam logic [2:0] SEL_CLEAR   = 3'b001;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT);
  localparam logic [3:0] LAT_PRE  = 4'(ALU_LAT - 1);

  seqState_t        stateQ, stateNext;
  logic [3:0]       phaseQ, phaseNext;
  logic [2:0]       opQ, opNext;
  logic [2:0]       accSelQ, accSelNext;
  logic [WIDTH-1:0] aluOperandQ, aluOperandNext;
  logic [6:0]       outSelQ, outSelNext;
  logic             resValidQ, resValidNext;
  logic [WIDTH-1:0] resDataQ, resDataNext;
  logic             resErrorQ, resErrorNext;
  logic             errFlagQ, errFlagNext;
  logic [CNT_W-1:0] opsCountQ, opsCountNext;

  logic       accept;
  logic       commit;
  logic       arithOp;
  logic       commitErr;
  logic [2:0] commitSel;
  logic [2:0] acceptSel;

  // A command is taken only in READY while powered; the commit edge is the
  // one where the phase counter has reached the ALU latency. Overflow only
  // means something for the arithmetic opcodes, so logic ops and LOAD never
  // raise an error even if the ALU overflow line happens to be high.
  assign accept    = (stateQ == READY) && bus.powerOn && bus.cmdValid;
  assign commit    = (stateQ == RUN) && (phaseQ == LAT_LAST);
  assign arithOp   = (opQ == OP_ADD) || (opQ == OP_SUB) || (opQ == OP_MULT);
  assign commitErr = commit && arithOp && bus.aluOverflow;
  assign commitSel = (opQ == OP_LOAD) ? SEL_LOAD : SEL_PERSIST;
  assign acceptSel = (bus.cmdOp == OP_LOAD) ? SEL_LOAD : SEL_PERSIST;

  // State register plus every registered output. Reset drops straight to
  // OFF and clears the accumulator, which also aborts any command in
  // flight without a result strobe or a count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= OFF;
      phaseQ      <= 4'd0;
      opQ         <= 3'd0;
      accSelQ     <= SEL_CLEAR;
      aluOperandQ <= '0;
      outSelQ     <= 7'd0;
      resValidQ   <= 1'b0;
      resDataQ    <= '0;
      resErrorQ   <= 1'b0;
      errFlagQ    <= 1'b0;
      opsCountQ   <= '0;
    end else begin
      stateQ      <= stateNext;
      phaseQ      <= phaseNext;
      opQ         <= opNext;
      accSelQ     <= accSelNext;
      aluOperandQ <= aluOperandNext;
      outSelQ     <= outSelNext;
      resValidQ   <= resValidNext;
      resDataQ    <= resDataNext;
      resErrorQ   <= resErrorNext;
      errFlagQ    <= errFlagNext;
      opsCountQ   <= opsCountNext;
    end
  end

  // Next-state logic. Losing powerOn in READY wins over a pending command;
  // in RUN power is ignored so the operation always completes, and an
  // overflow detours through a single RUN_ERROR cycle before READY.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      OFF: begin
        if (bus.powerOn) stateNext = READY;
      end
      READY: begin
        if (!bus.powerOn)  stateNext = OFF;
        else if (accept)   stateNext = RUN;
      end
      RUN: begin
        if (commit) stateNext = commitErr ? RUN_ERROR : READY;
      end
      RUN_ERROR: begin
        stateNext = READY;
      end
      default: stateNext = OFF;
    endcase
  end

  // Next values for the registered outputs. The accumulator select is
  // loaded one edge early so that it is asserted during the cycle that ends
  // on the commit edge; with a latency of one that early edge is the accept
  // edge itself. The operand and output select are frozen at accept, so
  // later command-bus activity cannot disturb a running operation. A new
  // error beats a coincident errClr.
  always_comb begin
    phaseNext      = phaseQ;
    opNext         = opQ;
    accSelNext     = SEL_HOLD;
    aluOperandNext = aluOperandQ;
    outSelNext     = outSelQ;
    resValidNext   = 1'b0;
    resDataNext    = resDataQ;
    resErrorNext   = 1'b0;
    errFlagNext    = bus.errClr ? 1'b0 : errFlagQ;
    opsCountNext   = opsCountQ;
    case (stateQ)
      READY: begin
        if (accept) begin
          opNext         = bus.cmdOp;
          aluOperandNext = bus.cmdOperand;
          outSelNext     = 7'd0;
          if (bus.cmdOp != OP_LOAD) outSelNext[bus.cmdOp] = 1'b1;
          phaseNext      = 4'd1;
          if (LAT_PRE == 4'd0) accSelNext = acceptSel;
        end
      end
      RUN: begin
        if (commit) begin
          resValidNext = 1'b1;
          resDataNext  = (opQ == OP_LOAD) ? aluOperandQ : bus.aluResult;
          if (opsCountQ != '1) opsCountNext = opsCountQ + CNT_W'(1);
          if (commitErr) begin
            resErrorNext = 1'b1;
            errFlagNext  = 1'b1;
            accSelNext   = SEL_CLEAR;
          end
        end else begin
          phaseNext = phaseQ + 4'd1;
          if (phaseQ == LAT_PRE) accSelNext = commitSel;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.cmdReady   = (stateQ == READY) && bus.powerOn;
  assign bus.state      = stateQ;
  assign bus.accSel     = accSelQ;
  assign bus.aluOperand = aluOperandQ;
  assign bus.outSel     = outSelQ;
  assign bus.resValid   = resValidQ;
  assign bus.resData    = resDataQ;
  assign bus.resError   = resErrorQ;
  assign bus.errFlag    = errFlagQ;
  assign bus.opsCount   = opsCountQ;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Drives the sequencer with directed and random commands. A behavioural
//   ALU with its own accumulator sits on the mux selects, and a command-level
//   model predicts each result, error, sticky flag and count. A second
//   instance with a 2-bit counter shadows the same stimulus for saturation.
module tb_alu_cmd_sequencer;

  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 2;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 2;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  envAcc;
  logic [7:0]  envRes;
  logic        envOvf;
  logic [8:0]  envSum;
  logic [15:0] envProd;
  bit          forceOvf;
  bit          noiseOvf;

  logic [7:0] modelAcc;
  int         modelCount;
  bit         modelErr;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifMain ();
  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(SAT_W)) ifSat ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(ifMain.slave)
  );

  alu_cmd_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .CNT_W(SAT_W)) dutSat (
    .clk(clk), .rst(rst), .bus(ifSat.slave)
  );

  assign ifSat.powerOn     = ifMain.powerOn;
  assign ifSat.cmdValid    = ifMain.cmdValid;
  assign ifSat.cmdOp       = ifMain.cmdOp;
  assign ifSat.cmdOperand  = ifMain.cmdOperand;
  assign ifSat.aluResult   = ifMain.aluResult;
  assign ifSat.aluOverflow = ifMain.aluOverflow;
  assign ifSat.errClr      = ifMain.errClr;

  // Behavioural accumulator, following whatever the sequencer selects.
  always @(posedge clk) begin
    case (ifMain.accSel)
      3'b100:  envAcc <= ifMain.aluResult;
      3'b010:  envAcc <= ifMain.aluOperand;
      3'b001:  envAcc <= 8'h00;
      default: ;
    endcase
  end

  // Behavioural ALU output mux. Non-arithmetic selections present a random
  // overflow level that the sequencer must ignore; forceOvf adds one anywhere.
  always_comb begin
    envSum  = {1'b0, envAcc} + {1'b0, ifMain.aluOperand};
    envProd = {8'h00, envAcc} * {8'h00, ifMain.aluOperand};
    envRes  = 8'h00;
    envOvf  = noiseOvf;
    case (ifMain.outSel)
      7'b0000001: envRes = envAcc & ifMain.aluOperand;
      7'b0000010: envRes = envAcc | ifMain.aluOperand;
      7'b0000100: envRes = envAcc ^ ifMain.aluOperand;
      7'b0001000: envRes = ~envAcc;
      7'b0010000: begin envRes = envSum[7:0]; envOvf = envSum[8]; end
      7'b0100000: begin envRes = envAcc - ifMain.aluOperand; envOvf = (ifMain.aluOperand > envAcc); end
      7'b1000000: begin envRes = envProd[7:0]; envOvf = |envProd[15:8]; end
      default: ;
    endcase
  end

  assign ifMain.aluResult   = envRes;
  assign ifMain.aluOverflow = envOvf | forceOvf;

  // Command-level reference: one call per completed command.
  function automatic void stepModel(input logic [2:0] op, input logic [7:0] opd, input bit frc,
                                    output logic [7:0] res, output bit err);
    logic [15:0] full;
    bit natural;
    natural = 1'b0;
    full    = 16'd0;
    case (op)
      3'd0: full = {8'h00, modelAcc & opd};
      3'd1: full = {8'h00, modelAcc | opd};
      3'd2: full = {8'h00, modelAcc ^ opd};
      3'd3: full = {8'h00, ~modelAcc};
      3'd4: begin full = 16'(modelAcc) + 16'(opd); natural = (full > 16'd255); end
      3'd5: begin full = {8'h00, 8'(modelAcc - opd)}; natural = (opd > modelAcc); end
      3'd6: begin full = 16'(modelAcc) * 16'(opd); natural = (full > 16'd255); end
      default: full = {8'h00, opd};
    endcase
    res = full[7:0];
    err = (op == 3'd4 || op == 3'd5 || op == 3'd6) && (natural || frc);
    modelAcc = err ? 8'h00 : res;
    modelCount++;
    if (err) modelErr = 1'b1;
  endfunction

  // Presents one command from a negedge, waits for acceptance, then watches
  // until the result strobe and returns what was seen along the way.
  task automatic runCmd(input logic [2:0] op, input logic [7:0] opd, input bit frc,
                        input bit clrAtCommit, input bit dropPower,
                        output int waitCyc, output int lat, output logic [7:0] data,
                        output logic dataErr, output logic [2:0] commitSel,
                        output logic [6:0] outSelSeen, output logic [1:0] runState,
                        output logic [1:0] stateAfter, output bit timedOut);
    bit done;
    ifMain.cmdValid   = 1'b1;
    ifMain.cmdOp      = op;
    ifMain.cmdOperand = opd;
    forceOvf = frc;
    noiseOvf = 1'($urandom_range(0, 1));
    waitCyc = 0; lat = 0; data = 8'h00; dataErr = 1'b0; commitSel = 3'b000;
    outSelSeen = 7'd0; runState = 2'b00; stateAfter = 2'b00; timedOut = 1'b0;
    #1;
    while (ifMain.cmdReady !== 1'b1 && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (waitCyc >= 20) begin
      timedOut = 1'b1;
      ifMain.cmdValid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ifMain.cmdValid   = 1'b0;
    ifMain.cmdOp      = 3'($urandom);
    ifMain.cmdOperand = 8'($urandom);
    if (dropPower) ifMain.powerOn = 1'b0;
    outSelSeen = ifMain.outSel;
    runState   = ifMain.state;
    commitSel  = ifMain.accSel;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      ifMain.errClr = clrAtCommit && (lat == ALU_LAT - 1);
      @(posedge clk);
      lat++;
      @(negedge clk);
      ifMain.errClr = 1'b0;
      if (commitSel == 3'b000) commitSel = ifMain.accSel;
      if (ifMain.resValid === 1'b1) begin
        data       = ifMain.resData;
        dataErr    = ifMain.resError;
        stateAfter = ifMain.state;
        done       = 1'b1;
      end
    end
    timedOut = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ifMain.state !== 2'b00) begin failures++; $display("[TB] FAIL reset_state actual=%b expected=00", ifMain.state); end
    checks++; if (ifMain.accSel !== 3'b001) begin failures++; $display("[TB] FAIL reset_accSel actual=%b expected=001", ifMain.accSel); end
    checks++; if (ifMain.opsCount !== 16'd0 || ifMain.errFlag !== 1'b0 || ifMain.resValid !== 1'b0)
      begin failures++; $display("[TB] FAIL reset_status actual=%0d/%b/%b expected=0/0/0", ifMain.opsCount, ifMain.errFlag, ifMain.resValid); end
    checks++; if (ifMain.outSel !== 7'd0 || ifMain.aluOperand !== 8'h00 || ifMain.cmdReady !== 1'b0)
      begin failures++; $display("[TB] FAIL reset_datapath actual=%b/%h/%b expected=0000000/00/0", ifMain.outSel, ifMain.aluOperand, ifMain.cmdReady); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ifMain.accSel !== 3'b000 || ifMain.state !== 2'b00)
      begin failures++; $display("[TB] FAIL off_idle actual=%b/%b expected=000/00", ifMain.accSel, ifMain.state); end
    ifMain.powerOn = 1'b1;
    #1;
    checks++; if (ifMain.cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL off_ready actual=%b expected=0", ifMain.cmdReady); end
    @(negedge clk);
    checks++; if (ifMain.state !== 2'b01 || ifMain.cmdReady !== 1'b1)
      begin failures++; $display("[TB] FAIL power_up actual=%b/%b expected=01/1", ifMain.state, ifMain.cmdReady); end
    modelAcc = 8'h00; modelCount = 0; modelErr = 1'b0;
  endtask

  task automatic test_load();
    int w, l; logic [7:0] d, er; logic e; logic [2:0] cs; logic [6:0] os; logic [1:0] rs, sa; bit to, ee;
    stepModel(3'd7, 8'h05, 1'b0, er, ee);
    runCmd(3'd7, 8'h05, 1'b0, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL load_timeout actual=timeout expected=res_valid"); end
    checks++; if (l != ALU_LAT) begin failures++; $display("[TB] FAIL load_latency actual=%0d expected=%0d", l, ALU_LAT); end
    checks++; if (cs !== 3'b010) begin failures++; $display("[TB] FAIL load_accSel actual=%b expected=010", cs); end
    checks++; if (d !== 8'h05 || e !== 1'b0) begin failures++; $display("[TB] FAIL load_data actual=%h/%b expected=05/0", d, e); end
    checks++; if (os !== 7'd0 || rs !== 2'b10) begin failures++; $display("[TB] FAIL load_run actual=%b/%b expected=0000000/10", os, rs); end
    checks++; if (ifMain.opsCount !== 16'd1) begin failures++; $display("[TB] FAIL load_count actual=%0d expected=1", ifMain.opsCount); end
  endtask

  task automatic test_add();
    int w, l; logic [7:0] d, er; logic e; logic [2:0] cs; logic [6:0] os; logic [1:0] rs, sa; bit to, ee;
    stepModel(3'd4, 8'h03, 1'b0, er, ee);
    runCmd(3'd4, 8'h03, 1'b0, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL add_timeout actual=timeout expected=res_valid"); end
    checks++; if (os !== 7'b0010000) begin failures++; $display("[TB] FAIL add_outSel actual=%b expected=0010000", os); end
    checks++; if (cs !== 3'b100) begin failures++; $display("[TB] FAIL add_accSel actual=%b expected=100", cs); end
    checks++; if (d !== 8'h08 || e !== 1'b0) begin failures++; $display("[TB] FAIL add_data actual=%h/%b expected=08/0", d, e); end
    checks++; if (ifMain.opsCount !== 16'd2 || sa !== 2'b01)
      begin failures++; $display("[TB] FAIL add_count actual=%0d/%b expected=2/01", ifMain.opsCount, sa); end
    @(negedge clk);
    checks++; if (ifMain.resValid !== 1'b0) begin failures++; $display("[TB] FAIL add_strobe actual=%b expected=0", ifMain.resValid); end
  endtask

  task automatic test_overflow();
    int w, l; logic [7:0] d, er; logic e; logic [2:0] cs; logic [6:0] os; logic [1:0] rs, sa; bit to, ee;
    stepModel(3'd7, 8'h20, 1'b0, er, ee);
    runCmd(3'd7, 8'h20, 1'b0, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    stepModel(3'd6, 8'h10, 1'b0, er, ee);
    runCmd(3'd6, 8'h10, 1'b0, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to || e !== 1'b1 || d !== 8'h00) begin failures++; $display("[TB] FAIL mult_ovf actual=%b/%h expected=1/00", e, d); end
    checks++; if (ifMain.errFlag !== 1'b1) begin failures++; $display("[TB] FAIL mult_errFlag actual=%b expected=1", ifMain.errFlag); end
    checks++; if (rs !== 2'b10 || sa !== 2'b11 || ifMain.accSel !== 3'b001)
      begin failures++; $display("[TB] FAIL run_error actual=%b/%b/%b expected=10/11/001", rs, sa, ifMain.accSel); end
    @(negedge clk);
    checks++; if (ifMain.state !== 2'b01 || ifMain.accSel !== 3'b000)
      begin failures++; $display("[TB] FAIL error_exit actual=%b/%b expected=01/000", ifMain.state, ifMain.accSel); end
    stepModel(3'd4, 8'h07, 1'b0, er, ee);
    runCmd(3'd4, 8'h07, 1'b0, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to || d !== 8'h07) begin failures++; $display("[TB] FAIL acc_cleared actual=%h expected=07", d); end
    stepModel(3'd0, 8'h0F, 1'b1, er, ee);
    runCmd(3'd0, 8'h0F, 1'b1, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to || d !== 8'h07 || e !== 1'b0 || sa !== 2'b01)
      begin failures++; $display("[TB] FAIL logic_ovf_ignored actual=%h/%b/%b expected=07/0/01", d, e, sa); end
  endtask

  task automatic test_err_clr();
    int w, l; logic [7:0] d, er; logic e; logic [2:0] cs; logic [6:0] os; logic [1:0] rs, sa; bit to, ee;
    ifMain.errClr = 1'b1;
    @(negedge clk);
    ifMain.errClr = 1'b0;
    modelErr = 1'b0;
    checks++; if (ifMain.errFlag !== 1'b0) begin failures++; $display("[TB] FAIL clr_first actual=%b expected=0", ifMain.errFlag); end
    stepModel(3'd7, 8'h10, 1'b0, er, ee);
    runCmd(3'd7, 8'h10, 1'b0, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    stepModel(3'd5, 8'h20, 1'b0, er, ee);
    runCmd(3'd5, 8'h20, 1'b0, 1'b1, 1'b0, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to || d !== 8'hF0 || e !== 1'b1) begin failures++; $display("[TB] FAIL sub_borrow actual=%h/%b expected=f0/1", d, e); end
    checks++; if (ifMain.errFlag !== 1'b1) begin failures++; $display("[TB] FAIL set_wins actual=%b expected=1", ifMain.errFlag); end
    @(negedge clk);
    ifMain.errClr = 1'b1;
    @(negedge clk);
    ifMain.errClr = 1'b0;
    modelErr = 1'b0;
    checks++; if (ifMain.errFlag !== 1'b0) begin failures++; $display("[TB] FAIL clr_alone actual=%b expected=0", ifMain.errFlag); end
  endtask

  task automatic test_power();
    int w, l; logic [7:0] d, er; logic e; logic [2:0] cs; logic [6:0] os; logic [1:0] rs, sa; bit to, ee;
    logic [7:0] opd;
    ifMain.cmdValid = 1'b1;
    ifMain.cmdOp    = 3'd1;
    ifMain.powerOn  = 1'b0;
    #1;
    checks++; if (ifMain.cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL power_ready actual=%b expected=0", ifMain.cmdReady); end
    @(negedge clk);
    checks++; if (ifMain.state !== 2'b00) begin failures++; $display("[TB] FAIL power_off actual=%b expected=00", ifMain.state); end
    @(negedge clk);
    checks++; if (ifMain.opsCount !== 16'(modelCount) || ifMain.resValid !== 1'b0)
      begin failures++; $display("[TB] FAIL power_noaccept actual=%0d/%b expected=%0d/0", ifMain.opsCount, ifMain.resValid, modelCount); end
    ifMain.cmdValid = 1'b0;
    ifMain.powerOn  = 1'b1;
    @(negedge clk);
    opd = 8'($urandom);
    stepModel(3'd2, opd, 1'b0, er, ee);
    runCmd(3'd2, opd, 1'b0, 1'b0, 1'b1, w, l, d, e, cs, os, rs, sa, to);
    checks++; if (to || d !== er || sa !== 2'b01) begin failures++; $display("[TB] FAIL power_drop_run actual=%h/%b expected=%h/01", d, sa, er); end
    @(negedge clk);
    checks++; if (ifMain.state !== 2'b00) begin failures++; $display("[TB] FAIL power_drop_off actual=%b expected=00", ifMain.state); end
    ifMain.powerOn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rst_mid_run();
    bit sawValid;
    ifMain.cmdValid   = 1'b1;
    ifMain.cmdOp      = 3'd4;
    ifMain.cmdOperand = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    ifMain.cmdValid = 1'b0;
    checks++; if (ifMain.state !== 2'b10) begin failures++; $display("[TB] FAIL midrun_enter actual=%b expected=10", ifMain.state); end
    rst = 1'b1;
    #1;
    checks++; if (ifMain.state !== 2'b00 || ifMain.accSel !== 3'b001)
      begin failures++; $display("[TB] FAIL midrun_abort actual=%b/%b expected=00/001", ifMain.state, ifMain.accSel); end
    sawValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifMain.resValid === 1'b1) sawValid = 1'b1;
    end
    checks++; if (sawValid || ifMain.opsCount !== 16'd0 || ifSat.opsCount !== 2'd0)
      begin failures++; $display("[TB] FAIL midrun_nores actual=%b/%0d expected=0/0", sawValid, ifMain.opsCount); end
    rst = 1'b0;
    modelAcc = 8'h00; modelCount = 0; modelErr = 1'b0;
    @(negedge clk);
    checks++; if (ifMain.state !== 2'b01) begin failures++; $display("[TB] FAIL midrun_recover actual=%b expected=01", ifMain.state); end
  endtask

  task automatic test_back_to_back();
    int w, l; logic [7:0] d, er; logic e; logic [2:0] cs; logic [6:0] os; logic [1:0] rs, sa; bit to, ee;
    logic [2:0] op; logic [7:0] opd; bit frc, prevErr;
    logic [6:0] expOs; logic [2:0] expCs; int satExp;
    prevErr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom);
      opd = 8'($urandom);
      frc = ($urandom_range(0, 7) == 0);
      stepModel(op, opd, frc, er, ee);
      expOs = 7'd0;
      if (op != 3'd7) expOs[op] = 1'b1;
      expCs = (op == 3'd7) ? 3'b010 : 3'b100;
      satExp = (modelCount > 3) ? 3 : modelCount;
      runCmd(op, opd, frc, 1'b0, 1'b0, w, l, d, e, cs, os, rs, sa, to);
      checks++; if (to || l != ALU_LAT) begin failures++; $display("[TB] FAIL rnd%0d_latency actual=%0d expected=%0d", i, l, ALU_LAT); end
      checks++; if (d !== er || e !== ee) begin failures++; $display("[TB] FAIL rnd%0d_result op=%0d actual=%h/%b expected=%h/%b", i, op, d, e, er, ee); end
      checks++; if (os !== expOs || cs !== expCs) begin failures++; $display("[TB] FAIL rnd%0d_sel actual=%b/%b expected=%b/%b", i, os, cs, expOs, expCs); end
      checks++; if (w != (prevErr ? 1 : 0)) begin failures++; $display("[TB] FAIL rnd%0d_throughput actual=%0d expected=%0d", i, w, prevErr ? 1 : 0); end
      checks++; if (ifMain.errFlag !== modelErr || ifMain.opsCount !== 16'(modelCount))
        begin failures++; $display("[TB] FAIL rnd%0d_status actual=%b/%0d expected=%b/%0d", i, ifMain.errFlag, ifMain.opsCount, modelErr, modelCount); end
      checks++; if (ifSat.opsCount !== 2'(satExp)) begin failures++; $display("[TB] FAIL rnd%0d_saturate actual=%0d expected=%0d", i, ifSat.opsCount, satExp); end
      prevErr = ee;
    end
  endtask

  initial begin
    rst = 1'b1;
    ifMain.powerOn = 1'b0; ifMain.cmdValid = 1'b0; ifMain.cmdOp = 3'd0;
    ifMain.cmdOperand = 8'h00; ifMain.errClr = 1'b0;
    forceOvf = 1'b0; noiseOvf = 1'b0;
    modelAcc = 8'h00; modelCount = 0; modelErr = 1'b0;
    test_reset();
    test_load();
    test_add();
    test_overflow();
    test_err_clr();
    test_power();
    test_rst_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
